// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
// Shares one req/ack memory port between the CPU instruction-fetch port and
// the data port. Arbitration is fixed priority (data wins) or round-robin.
// An optional ack timeout aborts a stuck access and flags it to the port.
module mem_bus_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int ARB_MODE   = 0,
  parameter int TIMEOUT    = 16
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_inst_req,
  input  logic [ADDR_WIDTH-1:0]   i_inst_addr,
  output logic [DATA_WIDTH-1:0]   o_inst_rdata,
  output logic                    o_inst_ready,
  output logic                    o_inst_err,
  input  logic                    i_data_req,
  input  logic                    i_data_we,
  input  logic [DATA_WIDTH/8-1:0] i_data_be,
  input  logic [ADDR_WIDTH-1:0]   i_data_addr,
  input  logic [DATA_WIDTH-1:0]   i_data_wdata,
  output logic [DATA_WIDTH-1:0]   o_data_rdata,
  output logic                    o_data_ready,
  output logic                    o_data_err,
  output logic                    o_mem_req,
  output logic                    o_mem_we,
  output logic [DATA_WIDTH/8-1:0] o_mem_be,
  output logic [ADDR_WIDTH-1:0]   o_mem_addr,
  output logic [DATA_WIDTH-1:0]   o_mem_wdata,
  input  logic [DATA_WIDTH-1:0]   i_mem_rdata,
  input  logic                    i_mem_ack
);

  localparam int BE_WIDTH  = DATA_WIDTH / 8;
  // The counter must be able to hold TIMEOUT itself; TIMEOUT=0 disables it.
  localparam int CNT_WIDTH = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_LIMIT = CNT_WIDTH'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef enum logic {
    PORT_INST = 1'b0,
    PORT_DATA = 1'b1
  } port_e;

  state_e                  state_q,      state_d;
  port_e                   last_grant_q, last_grant_d;
  port_e                   grant_q,      grant_d;
  logic [CNT_WIDTH-1:0]    cnt_q,        cnt_d;

  logic                    mem_req_q,    mem_req_d;
  logic                    mem_we_q,     mem_we_d;
  logic [BE_WIDTH-1:0]     mem_be_q,     mem_be_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q,   mem_addr_d;
  logic [DATA_WIDTH-1:0]   mem_wdata_q,  mem_wdata_d;

  logic [DATA_WIDTH-1:0]   inst_rdata_q, inst_rdata_d;
  logic                    inst_ready_q, inst_ready_d;
  logic                    inst_err_q,   inst_err_d;
  logic [DATA_WIDTH-1:0]   data_rdata_q, data_rdata_d;
  logic                    data_ready_q, data_ready_d;
  logic                    data_err_q,   data_err_d;

  logic                    pick_data;
  logic [CNT_WIDTH-1:0]    cnt_inc;
  logic                    timeout_hit;

  // Decide which port wins if a grant happens this cycle.
  always_comb begin
    pick_data = 1'b0;
    if (i_data_req && i_inst_req) begin
      if (ARB_MODE == 1) begin
        pick_data = (last_grant_q == PORT_INST);
      end else begin
        pick_data = 1'b1;
      end
    end else begin
      pick_data = i_data_req;
    end
  end

  // Wait-cycle count this cycle would reach, and whether that is a timeout.
  always_comb begin
    cnt_inc     = cnt_q + CNT_WIDTH'(1);
    timeout_hit = (TIMEOUT != 0) && (cnt_inc == CNT_LIMIT);
  end

  // Next-state and registered-output logic for the IDLE/BUSY/RESP sequence.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    cnt_d        = cnt_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_be_d     = mem_be_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    inst_rdata_d = inst_rdata_q;
    inst_ready_d = 1'b0;
    inst_err_d   = 1'b0;
    data_rdata_d = data_rdata_q;
    data_ready_d = 1'b0;
    data_err_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_inst_req || i_data_req) begin
          state_d   = BUSY;
          cnt_d     = '0;
          mem_req_d = 1'b1;
          if (pick_data) begin
            grant_d      = PORT_DATA;
            last_grant_d = PORT_DATA;
            mem_we_d     = i_data_we;
            mem_be_d     = i_data_be;
            mem_addr_d   = i_data_addr;
            mem_wdata_d  = i_data_wdata;
          end else begin
            grant_d      = PORT_INST;
            last_grant_d = PORT_INST;
            mem_we_d     = 1'b0;
            mem_be_d     = '1;
            mem_addr_d   = i_inst_addr;
            mem_wdata_d  = '0;
          end
        end
      end

      BUSY: begin
        if (i_mem_ack || timeout_hit) begin
          state_d     = RESP;
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          mem_be_d    = '0;
          mem_addr_d  = '0;
          mem_wdata_d = '0;
          if (!i_mem_ack) begin
            cnt_d = cnt_inc;
          end
          if (grant_q == PORT_DATA) begin
            data_ready_d = 1'b1;
            data_err_d   = !i_mem_ack;
            if (!i_mem_ack) begin
              data_rdata_d = '0;
            end else if (!mem_we_q) begin
              data_rdata_d = i_mem_rdata;
            end
          end else begin
            inst_ready_d = 1'b1;
            inst_err_d   = !i_mem_ack;
            inst_rdata_d = i_mem_ack ? i_mem_rdata : '0;
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end

      RESP: begin
        state_d = IDLE;
        cnt_d   = '0;
      end

      default: begin
        state_d     = IDLE;
        cnt_d       = '0;
        mem_req_d   = 1'b0;
        mem_we_d    = 1'b0;
        mem_be_d    = '0;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
      end
    endcase
  end

  // State and output registers; reset clears everything immediately.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q      <= IDLE;
      last_grant_q <= PORT_INST;
      grant_q      <= PORT_INST;
      cnt_q        <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_be_q     <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      inst_rdata_q <= '0;
      inst_ready_q <= 1'b0;
      inst_err_q   <= 1'b0;
      data_rdata_q <= '0;
      data_ready_q <= 1'b0;
      data_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      cnt_q        <= cnt_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_be_q     <= mem_be_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      inst_rdata_q <= inst_rdata_d;
      inst_ready_q <= inst_ready_d;
      inst_err_q   <= inst_err_d;
      data_rdata_q <= data_rdata_d;
      data_ready_q <= data_ready_d;
      data_err_q   <= data_err_d;
    end
  end

  assign o_mem_req    = mem_req_q;
  assign o_mem_we     = mem_we_q;
  assign o_mem_be     = mem_be_q;
  assign o_mem_addr   = mem_addr_q;
  assign o_mem_wdata  = mem_wdata_q;
  assign o_inst_rdata = inst_rdata_q;
  assign o_inst_ready = inst_ready_q;
  assign o_inst_err   = inst_err_q;
  assign o_data_rdata = data_rdata_q;
  assign o_data_ready = data_ready_q;
  assign o_data_err   = data_err_q;

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
Parametrised successor of the split ROM/RAM CPU top-level. It merges the CPU instruction-fetch port and data port onto a single shared memory port. Arbitration is either fixed-priority or round-robin. The memory side uses a req/ack handshake with a programmable timeout and per-port error reporting. It sits between the cpu/cpu_pipeline core and a unified memory, so a wait-stated memory can replace the zero-latency ROM/RAM.

Parameters:
DATA_WIDTH, 32, data bus width in bits; must be a multiple of 8
ADDR_WIDTH, 32, address width in bits
ARB_MODE, 0, 0 = data port always wins contention; 1 = round-robin
TIMEOUT, 16, cycles to wait for i_mem_ack before aborting with error; 0 = never time out

Ports:
i_clk  in  1  clock, rising edge
i_rst  in  1  reset, asynchronous, active-low
i_inst_req  in  1  fetch request; held until o_inst_ready
i_inst_addr  in  ADDR_WIDTH  fetch address
o_inst_rdata  out  DATA_WIDTH  fetched word; held until next fetch completes
o_inst_ready  out  1  one-cycle completion pulse
o_inst_err  out  1  timeout flag; valid with o_inst_ready
i_data_req  in  1  data request; held until o_data_ready
i_data_we  in  1  1 = write, 0 = read
i_data_be  in  DATA_WIDTH/8  byte enables for writes
i_data_addr  in  ADDR_WIDTH  data address
i_data_wdata  in  DATA_WIDTH  write data
o_data_rdata  out  DATA_WIDTH  read data; held until next data completion
o_data_ready  out  1  one-cycle completion pulse
o_data_err  out  1  timeout flag; valid with o_data_ready
o_mem_req  out  1  memory request; held until ack or timeout
o_mem_we  out  1  memory write strobe
o_mem_be  out  DATA_WIDTH/8  memory byte enables
o_mem_addr  out  ADDR_WIDTH  memory address
o_mem_wdata  out  DATA_WIDTH  memory write data
i_mem_rdata  in  DATA_WIDTH  memory read data; valid with i_mem_ack
i_mem_ack  in  1  memory completion

Behaviour:
- Reset is asynchronous and active-low. While i_rst=0, every output is 0, state = IDLE, last_grant = INST, and the timeout counter = 0. Reset asserted mid-transaction drops o_mem_req immediately, with no ready or err pulse.
- States: IDLE, BUSY, RESP.
- IDLE with no request pending: stay in IDLE; memory outputs stay 0.
- IDLE with a request pending: grant one port, register the memory outputs from it, go to BUSY.
- Grant, ARB_MODE=0: data beats inst.
- Grant, ARB_MODE=1: on contention, grant the port not in last_grant. last_grant updates at every grant.
- Inst grant drives o_mem_we=0, o_mem_be=all ones, o_mem_wdata=0.
- Data grant copies i_data_we, i_data_be, i_data_addr and i_data_wdata.
- Port inputs are sampled only at grant. Changes after grant are ignored.
- BUSY: o_mem_req=1; all memory outputs held stable. The counter increments each cycle without ack.
- BUSY with i_mem_ack=1 and a granted read: capture i_mem_rdata into the granted port's rdata register; go to RESP with err=0.
- BUSY with i_mem_ack=1 and a granted write: the port's rdata register is unchanged; go to RESP with err=0.
- BUSY timeout: when TIMEOUT!=0 and the counter reaches TIMEOUT without ack, go to RESP with err=1. The port's rdata register is set to 0.
- Ack arriving in the same cycle as the timeout is treated as a normal ack.
- RESP: o_mem_req=0. The granted port's ready pulses for exactly one cycle, with err valid in that cycle. Counter clears; go to IDLE.
- Requester rule: a port keeps req asserted through its ready cycle. The arbiter never re-grants a port in the RESP cycle.
- Latency: request seen in IDLE at cycle N gives o_mem_req=1 at N+1. Ack at N+k gives ready at N+k+1.
- Minimum occupancy is 3 cycles per transaction. The losing port waits, with no ready, until the next IDLE.
- o_mem_req is never asserted in IDLE or RESP. At most one ready pulse per cycle.
- err and ready are registered outputs. err is 0 whenever ready is 0.

Test Plan:
- Hold i_rst=0 with random inputs -> all outputs 0. Release i_rst -> o_mem_req stays 0 until a req.
- Fetch i_inst_addr=0x100; i_mem_ack 2 cycles after o_mem_req with i_mem_rdata=0x00000013 -> o_mem_addr=0x100, o_mem_we=0, o_mem_be=0xF; one-cycle o_inst_ready with o_inst_rdata=0x00000013 and o_inst_err=0.
- ARB_MODE=0, fetch 0x104 and data write 0x2000/0xDEADBEEF/be 0x3 requested in the same cycle, ack each after 1 cycle -> data write issued first with o_mem_be=0x3 and o_mem_we=1; fetch issued after; o_data_ready precedes o_inst_ready.
- ARB_MODE=1, both reqs held continuously, immediate acks -> grant order D, I, D, I for 8 transactions; each ready exactly once per transaction.
- TIMEOUT=4, data read 0x3000, no ack -> o_mem_req high exactly 4 cycles, then o_data_ready=1 with o_data_err=1 and o_data_rdata=0. Same test with ack in cycle 4 -> err=0 and rdata captured.
- Pulse i_rst low during BUSY -> o_mem_req=0 immediately, no ready pulse. A new fetch after release completes normally.
